// File: rtl/traffic_light_monitor.sv
// Traffic light monitor: decodes four observed lamp groups into a phase, checks ordering and dwell times.
// Define TLM_FAULT_COUNT_EN to add the saturating fault_cnt error-event counter port.

module traffic_light_monitor #(
    parameter int GREEN_CYC  = 7,
    parameter int YELLOW_CYC = 3
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic       clr,
    input  logic [2:0] n_lights,
    input  logic [2:0] s_lights,
    input  logic [2:0] e_lights,
    input  logic [2:0] w_lights,
    output logic [2:0] phase,
    output logic       phase_vld,
    output logic       err_conflict,
    output logic       err_pattern,
    output logic       err_seq,
    output logic       err_dur,
    output logic       fault,
    output logic [7:0] round_cnt
`ifdef TLM_FAULT_COUNT_EN
    ,
    output logic [7:0] fault_cnt
`endif
);

    localparam logic [2:0] LAMP_GREEN   = 3'b001;
    localparam logic [2:0] LAMP_YELLOW  = 3'b010;
    localparam logic [2:0] LAMP_RED     = 3'b100;
    localparam logic [3:0] GREEN_DWELL  = 4'(GREEN_CYC);
    localparam logic [3:0] YELLOW_DWELL = 4'(YELLOW_CYC);
    localparam logic [3:0] DWELL_MAX    = 4'd15;
    localparam logic [2:0] PH_N         = 3'd0;
    localparam logic [2:0] PH_W_Y       = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [2:0] lamp_in [4];
    logic [2:0] lamp_q  [4];
    logic [2:0] lamp_d  [4];
    logic       in_vld_q, in_vld_d;
    logic [2:0] phase_q, phase_d;
    logic       phase_vld_q, phase_vld_d;
    logic [3:0] err_q, err_d;      // {dur, seq, pattern, conflict}
    logic       fault_q, fault_d;
    logic [3:0] dwell_q, dwell_d;
    logic       first_q, first_d;
    logic [7:0] round_q, round_d;

    logic [3:0] not_red, bad_code, is_yellow;
    logic [2:0] lit_cnt;
    logic [2:0] dec_phase;
    logic       legal, conflict_det, pattern_det;
    logic       same_phase, tracking, seq_det, dur_det;
    logic [2:0] phase_succ;
    logic [3:0] dwell_exp;
    logic [3:0] new_err;

    assign lamp_in[0] = n_lights;
    assign lamp_in[1] = s_lights;
    assign lamp_in[2] = e_lights;
    assign lamp_in[3] = w_lights;

    for (genvar gi = 0; gi < 4; gi++) begin : g_dir
        assign not_red[gi]   = (lamp_q[gi] != LAMP_RED);
        assign bad_code[gi]  = (lamp_q[gi] != LAMP_GREEN) && (lamp_q[gi] != LAMP_YELLOW)
                               && (lamp_q[gi] != LAMP_RED);
        assign is_yellow[gi] = (lamp_q[gi] == LAMP_YELLOW);
    end

    // in_vld_q masks the all-red reset contents of the input registers from the checks.
    always_comb begin : p_decode
        lit_cnt   = 3'd0;
        dec_phase = 3'd0;
        for (int i = 0; i < 4; i++) begin
            lamp_d[i] = lamp_in[i];
            lit_cnt   = lit_cnt + {2'b00, not_red[i]};
            if (not_red[i]) begin
                dec_phase = {2'(i), is_yellow[i]};
            end
        end
        in_vld_d     = 1'b1;
        conflict_det = in_vld_q && (lit_cnt > 3'd1);
        pattern_det  = in_vld_q && ((|bad_code) || (lit_cnt == 3'd0));
        legal        = in_vld_q && (lit_cnt == 3'd1) && !(|bad_code);
    end

    always_ff @(posedge clk or posedge rst_a) begin : p_state_reg
        if (rst_a) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin : p_next_state
        state_d = state_q;
        if (clr) begin
            state_d = ST_IDLE;
        end else if (|err_d) begin
            state_d = ST_FAULT;
        end else if ((state_q == ST_IDLE) && legal) begin
            state_d = ST_TRACK;
        end
    end

    always_comb begin : p_out_comb
        phase_succ  = phase_q + 3'd1;
        same_phase  = (dec_phase == phase_q);
        dwell_exp   = phase_q[0] ? YELLOW_DWELL : GREEN_DWELL;
        tracking    = (state_q == ST_TRACK) && legal;
        seq_det     = tracking && !same_phase && (dec_phase != phase_succ);
        // Same phase at the expected dwell means this cycle overstays; flag it now.
        dur_det     = tracking && !first_q &&
                      (same_phase ? (dwell_q == dwell_exp) : (dwell_q != dwell_exp));
        new_err     = {dur_det, seq_det, pattern_det, conflict_det};
        err_d       = clr ? 4'b0000 : (err_q | new_err);
        fault_d     = |err_d;
        phase_d     = legal ? dec_phase : phase_q;
        phase_vld_d = legal;

        dwell_d = dwell_q;
        first_d = first_q;
        if ((state_q == ST_IDLE) && legal) begin
            dwell_d = 4'd1;
            first_d = 1'b1;
        end else if (tracking) begin
            if (same_phase) begin
                if (dwell_q != DWELL_MAX) begin
                    dwell_d = dwell_q + 4'd1;
                end
            end else begin
                dwell_d = 4'd1;
                first_d = 1'b0;
            end
        end

        round_d = round_q;
        if (tracking && (phase_q == PH_W_Y) && (dec_phase == PH_N) && (new_err == 4'b0000)) begin
            round_d = round_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst_a) begin : p_regs
        if (rst_a) begin
            for (int i = 0; i < 4; i++) begin
                lamp_q[i] <= LAMP_RED;
            end
            in_vld_q    <= 1'b0;
            phase_q     <= 3'd0;
            phase_vld_q <= 1'b0;
            err_q       <= 4'b0000;
            fault_q     <= 1'b0;
            dwell_q     <= 4'd0;
            first_q     <= 1'b0;
            round_q     <= 8'd0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                lamp_q[i] <= lamp_d[i];
            end
            in_vld_q    <= in_vld_d;
            phase_q     <= phase_d;
            phase_vld_q <= phase_vld_d;
            err_q       <= err_d;
            fault_q     <= fault_d;
            dwell_q     <= dwell_d;
            first_q     <= first_d;
            round_q     <= round_d;
        end
    end

`ifdef TLM_FAULT_COUNT_EN
    logic [7:0] fault_cnt_q, fault_cnt_d;

    always_comb begin : p_fault_cnt
        fault_cnt_d = fault_cnt_q;
        if ((|(err_d & ~err_q)) && (fault_cnt_q != 8'hFF)) begin
            fault_cnt_d = fault_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst_a) begin : p_fault_cnt_reg
        if (rst_a) begin
            fault_cnt_q <= 8'd0;
        end else begin
            fault_cnt_q <= fault_cnt_d;
        end
    end

    assign fault_cnt = fault_cnt_q;
`endif

    assign phase        = phase_q;
    assign phase_vld    = phase_vld_q;
    assign err_conflict = err_q[0];
    assign err_pattern  = err_q[1];
    assign err_seq      = err_q[2];
    assign err_dur      = err_q[3];
    assign fault        = fault_q;
    assign round_cnt    = round_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: decode table, directed multi-cycle sequences and random stimulus
// compared every cycle against a run-length reference model.

module tb_traffic_light_monitor;

    localparam int GREEN  = 7;
    localparam int YELLOW = 3;

    logic       clk = 1'b0;
    logic       rst_a, clr;
    logic [2:0] n_l, s_l, e_l, w_l;
    logic [2:0] phase;
    logic       phase_vld, err_conflict, err_pattern, err_seq, err_dur, fault;
    logic [7:0] round_cnt;
`ifdef TLM_FAULT_COUNT_EN
    logic [7:0] fault_cnt;
`endif

    always #5 clk = ~clk;

    traffic_light_monitor #(.GREEN_CYC(GREEN), .YELLOW_CYC(YELLOW)) dut (
        .clk(clk), .rst_a(rst_a), .clr(clr),
        .n_lights(n_l), .s_lights(s_l), .e_lights(e_l), .w_lights(w_l),
        .phase(phase), .phase_vld(phase_vld),
        .err_conflict(err_conflict), .err_pattern(err_pattern),
        .err_seq(err_seq), .err_dur(err_dur), .fault(fault),
        .round_cnt(round_cnt)
`ifdef TLM_FAULT_COUNT_EN
        , .fault_cnt(fault_cnt)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference model: per-cycle view of the registered lamps, tracked as runs of phases.
    int         m_mode;            // 0 idle, 1 tracking, 2 fault
    int         m_phase;
    bit         m_vld;
    logic [3:0] m_err;             // {dur, seq, pattern, conflict}
    int         m_round, m_fcnt, m_run;
    bit         m_first;
    logic [2:0] prev_l [4];
    bit         prev_v;

    function automatic int exp_len(input int ph);
        return (ph % 2 == 1) ? YELLOW : GREEN;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_vld = 0; m_err = 4'b0000;
        m_round = 0; m_fcnt = 0; m_run = 0; m_first = 0;
        for (int i = 0; i < 4; i++) prev_l[i] = 3'b100;
        prev_v = 0;
    endtask

    task automatic model_step(input bit c);
        int nonred, dir, ph;
        bit bad, conf, patt, legal, rinc;
        logic [3:0] newe;
        nonred = 0; dir = 0; bad = 0; rinc = 0;
        if (prev_v) begin
            for (int i = 0; i < 4; i++) begin
                if (prev_l[i] != 3'b100) begin nonred++; dir = i; end
                if (!(prev_l[i] == 3'b001 || prev_l[i] == 3'b010 || prev_l[i] == 3'b100)) bad = 1;
            end
        end
        conf  = prev_v && (nonred >= 2);
        patt  = prev_v && (bad || nonred == 0);
        legal = prev_v && !conf && !patt;
        ph    = dir * 2 + ((prev_l[dir] == 3'b010) ? 1 : 0);
        newe  = {2'b00, patt, conf};
        if (m_mode == 1 && legal) begin
            if (ph == m_phase) begin
                if (!m_first && m_run == exp_len(m_phase)) newe[3] = 1'b1;
                m_run++;
            end else begin
                if (ph != (m_phase + 1) % 8) newe[2] = 1'b1;
                if (!m_first && m_run != exp_len(m_phase)) newe[3] = 1'b1;
                m_run = 1;
                m_first = 0;
            end
            if (m_phase == 7 && ph == 0 && newe == 4'b0000) rinc = 1;
        end
        if (legal) m_phase = ph;
        m_vld = legal;
        if (rinc) m_round = (m_round + 1) % 256;
        if (c) begin
            m_err = 4'b0000;
            m_mode = 0;
        end else begin
            if (((newe & ~m_err) != 4'b0000) && m_fcnt < 255) m_fcnt++;
            m_err = m_err | newe;
            if (m_err != 4'b0000) m_mode = 2;
            else if (m_mode == 0 && legal) begin
                m_mode = 1; m_run = 1; m_first = 1;
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int want);
        tests++;
        if (got != want) begin
            fails++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    task automatic check_model();
        logic [3:0] got_err;
        bit bad;
        got_err = {err_dur, err_seq, err_pattern, err_conflict};
        bad = (phase !== 3'(m_phase)) || (phase_vld !== m_vld) || (got_err !== m_err) ||
              (fault !== (|m_err)) || (round_cnt !== 8'(m_round));
`ifdef TLM_FAULT_COUNT_EN
        bad = bad || (fault_cnt !== 8'(m_fcnt));
`endif
        tests++;
        if (bad) begin
            fails++;
            $display("FAIL model t=%0t: got ph=%0d vld=%b err=%b flt=%b rnd=%0d, want ph=%0d vld=%b err=%b flt=%b rnd=%0d",
                     $time, phase, phase_vld, got_err, fault, round_cnt,
                     m_phase, m_vld, m_err, |m_err, m_round);
        end
    endtask

    // Drive one cycle of inputs, let one rising edge pass, then compare with the model.
    task automatic tick(input logic [2:0] n, input logic [2:0] s, input logic [2:0] e,
                        input logic [2:0] w, input logic c);
        n_l = n; s_l = s; e_l = e; w_l = w; clr = c;
        @(posedge clk);
        model_step(c);
        prev_l[0] = n; prev_l[1] = s; prev_l[2] = e; prev_l[3] = w;
        prev_v = 1;
        #1;
        check_model();
    endtask

    task automatic drive_ph(input int ph, input int k);
        logic [2:0] l [4];
        for (int i = 0; i < 4; i++) l[i] = 3'b100;
        l[ph / 2] = (ph % 2 == 1) ? 3'b010 : 3'b001;
        repeat (k) tick(l[0], l[1], l[2], l[3], 1'b0);
    endtask

    task automatic do_reset();
        rst_a = 1'b1; clr = 1'b0;
        n_l = 3'b100; s_l = 3'b100; e_l = 3'b100; w_l = 3'b100;
        #1;
        model_reset();
        chk("rst_async", int'({phase, phase_vld, err_dur, err_seq, err_pattern, err_conflict, fault, round_cnt}), 0);
        @(posedge clk);
        #2;
        rst_a = 1'b0;
    endtask

    typedef struct {
        logic [2:0] n, s, e, w;
        logic [2:0] ph;
        logic       vld, conf, patt;
    } vec_t;

    vec_t vecs [13];

    initial begin
        int g_ph, g_left, r;
        logic [2:0] l [4];
        logic c;

        vecs[0]  = '{3'b001, 3'b100, 3'b100, 3'b100, 3'd0, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{3'b010, 3'b100, 3'b100, 3'b100, 3'd1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{3'b100, 3'b001, 3'b100, 3'b100, 3'd2, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{3'b100, 3'b010, 3'b100, 3'b100, 3'd3, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{3'b100, 3'b100, 3'b001, 3'b100, 3'd4, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{3'b100, 3'b100, 3'b010, 3'b100, 3'd5, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{3'b100, 3'b100, 3'b100, 3'b001, 3'd6, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{3'b100, 3'b100, 3'b100, 3'b010, 3'd7, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{3'b100, 3'b100, 3'b100, 3'b100, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{3'b001, 3'b100, 3'b001, 3'b100, 3'd0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{3'b011, 3'b100, 3'b100, 3'b100, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{3'b000, 3'b100, 3'b100, 3'b100, 3'd0, 1'b0, 1'b0, 1'b1};
        vecs[12] = '{3'b111, 3'b001, 3'b100, 3'b100, 3'd0, 1'b0, 1'b1, 1'b1};

        rst_a = 1'b0; clr = 1'b0;
        n_l = 3'b100; s_l = 3'b100; e_l = 3'b100; w_l = 3'b100;
        #1;
        do_reset();

        // Decode table: fresh reset, hold the pattern two cycles, check the registered result.
        for (int v = 0; v < 13; v++) begin
            do_reset();
            tick(vecs[v].n, vecs[v].s, vecs[v].e, vecs[v].w, 1'b0);
            tick(vecs[v].n, vecs[v].s, vecs[v].e, vecs[v].w, 1'b0);
            chk("tbl_phase", int'(phase), int'(vecs[v].ph));
            chk("tbl_vld", int'(phase_vld), int'(vecs[v].vld));
            chk("tbl_conflict", int'(err_conflict), int'(vecs[v].conf));
            chk("tbl_pattern", int'(err_pattern), int'(vecs[v].patt));
            chk("tbl_fault", int'(fault), int'(vecs[v].conf | vecs[v].patt));
            $display("[TB] vector %0d lamps %b %b %b %b -> phase %0d vld %b", v,
                     vecs[v].n, vecs[v].s, vecs[v].e, vecs[v].w, phase, phase_vld);
        end

        // Full legal round with lag probe, then reset mid-E.
        do_reset();
        drive_ph(0, 8); drive_ph(1, 3);
        drive_ph(2, 1); chk("lag_ny", int'(phase), 1);
        drive_ph(2, 1); chk("lag_s", int'(phase), 2);
        drive_ph(2, 5); drive_ph(3, 3); drive_ph(4, 7); drive_ph(5, 3);
        drive_ph(6, 7); drive_ph(7, 3); drive_ph(0, 3);
        chk("round_one", int'(round_cnt), 1);
        chk("round_errs", int'({err_dur, err_seq, err_pattern, err_conflict}), 0);
        chk("round_phase", int'(phase), 0);
        $display("[TB] legal round: round_cnt=%0d fault=%b", round_cnt, fault);
        drive_ph(0, 4); drive_ph(1, 3); drive_ph(2, 7); drive_ph(3, 3); drive_ph(4, 3);
        chk("pre_rst_round", int'(round_cnt), 1);
        do_reset();
        drive_ph(4, 2); drive_ph(5, 3); drive_ph(6, 2);
        chk("post_rst_errs", int'({err_dur, err_seq, err_pattern, err_conflict}), 0);
        $display("[TB] reset mid-E: phase=%0d fault=%b", phase, fault);

        // Conflict: N green and E green together.
        do_reset();
        drive_ph(0, 8); drive_ph(1, 2);
        tick(3'b001, 3'b100, 3'b001, 3'b100, 1'b0);
        chk("conf_latency", int'(err_conflict), 0);
        drive_ph(1, 1);
        chk("conf_flag", int'(err_conflict), 1);
        chk("conf_fault", int'(fault), 1);
        chk("conf_vld", int'(phase_vld), 0);
        chk("conf_hold", int'(phase), 1);
        $display("[TB] conflict: err_conflict=%b phase=%0d", err_conflict, phase);

        // Sequence skip N_Y -> E, then legal continuation.
        do_reset();
        drive_ph(0, 8); drive_ph(1, 3); drive_ph(4, 7); drive_ph(5, 3);
        drive_ph(6, 7); drive_ph(7, 3); drive_ph(0, 2);
        chk("seq_flag", int'(err_seq), 1);
        chk("seq_no_dur", int'(err_dur), 0);
        chk("seq_round", int'(round_cnt), 0);
        $display("[TB] skip: err_seq=%b err_dur=%b", err_seq, err_dur);

        // Green too long, then green too short.
        do_reset();
        drive_ph(0, 8); drive_ph(1, 3); drive_ph(2, 8);
        chk("long_before", int'(err_dur), 0);
        drive_ph(2, 1);
        chk("long_flag", int'(err_dur), 1);
        chk("long_no_seq", int'(err_seq), 0);
        do_reset();
        drive_ph(0, 8); drive_ph(1, 3); drive_ph(2, 6); drive_ph(3, 1);
        chk("short_before", int'(err_dur), 0);
        drive_ph(3, 1);
        chk("short_flag", int'(err_dur), 1);
        $display("[TB] dwell: err_dur=%b", err_dur);

        // Bad code 011 cleared on the same edge it is detected.
        do_reset();
        drive_ph(0, 8); drive_ph(1, 3); drive_ph(2, 2);
        tick(3'b011, 3'b100, 3'b100, 3'b100, 1'b0);
        chk("clr_latency", int'(err_pattern), 0);
        tick(3'b100, 3'b010, 3'b100, 3'b100, 1'b1);
        chk("clr_wins", int'({err_dur, err_seq, err_pattern, err_conflict}), 0);
        drive_ph(3, 2); drive_ph(4, 2);
        chk("clr_idle", int'({err_dur, err_seq, err_pattern, err_conflict}), 0);
        $display("[TB] clr race: fault=%b", fault);

        // round_cnt wraps after 256 rounds.
        do_reset();
        drive_ph(0, 8);
        for (int k = 0; k < 256; k++) begin
            drive_ph(1, 3); drive_ph(2, 7); drive_ph(3, 3); drive_ph(4, 7);
            drive_ph(5, 3); drive_ph(6, 7); drive_ph(7, 3); drive_ph(0, 7);
            if (k == 254) chk("round_255", int'(round_cnt), 255);
        end
        chk("round_wrap", int'(round_cnt), 0);
        $display("[TB] wrap: round_cnt=%0d", round_cnt);

`ifdef TLM_FAULT_COUNT_EN
        do_reset();
        for (int k = 0; k < 300; k++) begin
            tick(3'b100, 3'b100, 3'b100, 3'b100, 1'b0);
            tick(3'b001, 3'b100, 3'b100, 3'b100, 1'b0);
            tick(3'b001, 3'b100, 3'b100, 3'b100, 1'b1);
        end
        chk("fault_cnt_sat", int'(fault_cnt), 255);
        $display("[TB] fault count: fault_cnt=%0d", fault_cnt);
`endif

        // Random mostly-legal traffic with dwell jitter, skips, garbage lamps, clr and resets.
        do_reset();
        g_ph = 0; g_left = GREEN + 1;
        for (int b = 0; b < 15; b++) begin
            for (int k = 0; k < 100; k++) begin
                r = $urandom_range(0, 199);
                if (r == 0) begin
                    do_reset();
                end else begin
                    if (g_left <= 0) begin
                        g_ph = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 7)) : (g_ph + 1) % 8;
                        g_left = exp_len(g_ph);
                        r = $urandom_range(0, 9);
                        if (r == 0) g_left++;
                        else if (r == 1) g_left--;
                        if (g_left < 1) g_left = 1;
                    end
                    for (int i = 0; i < 4; i++) l[i] = 3'b100;
                    l[g_ph / 2] = (g_ph % 2 == 1) ? 3'b010 : 3'b001;
                    if ($urandom_range(0, 49) == 0) l[$urandom_range(0, 3)] = 3'($urandom_range(0, 7));
                    c = ($urandom_range(0, 29) == 0);
                    tick(l[0], l[1], l[2], l[3], c);
                    g_left--;
                end
            end
            $display("[TB] random burst %0d: phase=%0d fault=%b round=%0d", b, phase, fault, round_cnt);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 The block SHALL have parameter GREEN_CYC, default 7, giving the required green dwell in clock cycles.
REQ-002 The block SHALL have parameter YELLOW_CYC, default 3, giving the required yellow dwell in clock cycles.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_a  input  1  reset; asynchronous, active-high.
REQ-005 clr  input  1  synchronous clear of sticky errors.
REQ-006 n_lights, s_lights, e_lights, w_lights  input  3 each  observed lamp codes: 001 green, 010 yellow, 100 red.
REQ-007 phase  output  3  decoded phase: 0 N, 1 N_Y, 2 S, 3 S_Y, 4 E, 5 E_Y, 6 W, 7 W_Y.
REQ-008 phase_vld  output  1  the sampled pattern is one of the 8 legal patterns.
REQ-009 err_conflict, err_pattern, err_seq, err_dur  output  1 each  sticky error flags.
REQ-010 fault  output  1  OR of the four error flags.
REQ-011 round_cnt  output  8  count of completed cycles through all four directions.
REQ-012 fault_cnt  output  8  saturating error-event count; present only under TLM_FAULT_COUNT_EN.

Function
REQ-013 All four light inputs SHALL be registered every clock; every decode and check SHALL use the registered copy; outputs SHALL be registered, giving 2-cycle latency from input to output.
REQ-014 A legal pattern SHALL be exactly one direction at 001 or 010 and the other three at 100; phase SHALL be set from the table in REQ-007.
REQ-015 On an illegal pattern: phase_vld=0, phase holds its last value.
REQ-016 Two or more directions not at 100: err_conflict SHALL set.
REQ-017 Any lamp code outside {001,010,100}, or all four directions at 100: err_pattern SHALL set.
REQ-018 FSM states: IDLE (wait for first legal phase), TRACK (checking), FAULT (any error set).
REQ-019 IDLE->TRACK on first legal pattern: dwell=1, first_phase=1.
REQ-020 TRACK, same phase: dwell increments, 4-bit, saturating at 15.
REQ-021 TRACK, phase change: successor SHALL be (prev+1) mod 8, otherwise err_seq; dwell resets to 1; first_phase clears.
REQ-022 TRACK, phase change with first_phase=0: the previous phase's dwell SHALL equal GREEN_CYC (even phase) or YELLOW_CYC (odd phase), otherwise err_dur (too short).
REQ-023 TRACK, same phase, first_phase=0, dwell equal to expected: err_dur SHALL set on that edge (too long); it SHALL NOT wait for the next phase change.
REQ-024 first_phase=1: no duration checks, because post-reset green legitimately dwells GREEN_CYC+1.
REQ-025 Transition W_Y->N with no error: round_cnt increments, wrapping 255->0.
REQ-026 Any error set: FSM->FAULT. In FAULT, phase/phase_vld keep decoding and conflict/pattern checks continue; sequence, duration and round_cnt updates are suspended.
REQ-027 Error flags SHALL be sticky until clr or rst_a.
REQ-028 clr=1: all error flags clear and FSM->IDLE; round_cnt is unaffected. An error detected in the same cycle is discarded (clr wins).

Reset
REQ-029 rst_a=1 SHALL immediately force: input registers=100 on all four directions, phase=0, phase_vld=0, all error flags and fault=0, round_cnt=0, fault_cnt=0, dwell=0, FSM=IDLE.
REQ-030 Reset asserted mid-phase SHALL discard all history; the first legal pattern after release is treated per REQ-019.

Configuration
REQ-031 Macro TLM_FAULT_COUNT_EN defined: fault_cnt SHALL exist and increment once per clock in which any error flag transitions 0->1, saturating at 255, cleared only by rst_a.
REQ-032 Macro TLM_FAULT_COUNT_EN undefined: port fault_cnt and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-033 Drive the legal sequence N×8, N_Y×3, S×7, S_Y×3, E×7, E_Y×3, W×7, W_Y×3, N -> no errors; round_cnt=1; phase tracks with 2-cycle lag.
REQ-034 Drive n_lights=001 and e_lights=001 together -> err_conflict=1, fault=1 two cycles later, phase_vld=0.
REQ-035 Drive N_Y directly to E -> err_seq=1; the sequence continues legally with no further err_dur.
REQ-036 Hold S green for 8 cycles after a checked N_Y -> err_dur sets on the edge dwell would reach 8; a 6-cycle green -> err_dur at the change.
REQ-037 Drive lamp code 011, then assert clr with that error on the same edge -> flags stay 0 and FSM is IDLE; rst_a pulse mid-E phase -> all outputs return to reset values.
REQ-038 With TLM_FAULT_COUNT_EN, cause 300 error events separated by clr -> fault_cnt=255.
